// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode constants, decoded-instruction record and the pure decode helpers
// used by the ID stage.
package decode_stage_pipe_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  localparam logic [2:0] LT_LB   = 3'b000;
  localparam logic [2:0] LT_LH   = 3'b001;
  localparam logic [2:0] LT_LW   = 3'b010;
  localparam logic [2:0] LT_LBU  = 3'b100;
  localparam logic [2:0] LT_LHU  = 3'b101;
  localparam logic [2:0] LT_NONE = 3'b111;
  localparam logic [1:0] ST_SB   = 2'b00;
  localparam logic [1:0] ST_SH   = 2'b01;
  localparam logic [1:0] ST_SW   = 2'b10;
  localparam logic [1:0] ST_NONE = 2'b11;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alu_src;
    logic        mem_write;
    logic        wb_load;
    logic        wb_reg_file;
    logic        m_type;
    logic        invalid;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_store_type;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i, input logic m_ext);
    dec_t d;
    d = '0;
    d.opcode = i[6:0];   d.func3 = i[14:12]; d.func7 = i[31:25];
    d.rs1    = i[19:15]; d.rs2   = i[24:20]; d.rd    = i[11:7];
    d.mem_load_type  = LT_NONE;
    d.mem_store_type = ST_NONE;
    case (i[6:0])
      OP_LUI, OP_AUIPC: begin
        d.imm = {i[31:12], 12'b0}; d.alu_src = 1'b1; d.wb_reg_file = 1'b1;
      end
      OP_JAL: begin
        d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        d.alu_src = 1'b1; d.wb_reg_file = 1'b1;
      end
      OP_JALR, OP_IMM: begin
        d.imm = {{20{i[31]}}, i[31:20]}; d.alu_src = 1'b1; d.wb_reg_file = 1'b1;
      end
      OP_LOAD: begin
        d.imm = {{20{i[31]}}, i[31:20]};
        d.alu_src = 1'b1; d.wb_load = 1'b1; d.wb_reg_file = 1'b1;
        case (i[14:12])
          LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU: d.mem_load_type = i[14:12];
          default: d.invalid = 1'b1;
        endcase
      end
      OP_STORE: begin
        d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; d.alu_src = 1'b1; d.mem_write = 1'b1;
        case (i[14:12])
          {1'b0, ST_SB}, {1'b0, ST_SH}, {1'b0, ST_SW}: d.mem_store_type = i[13:12];
          default: d.invalid = 1'b1;
        endcase
      end
      OP_BRANCH: d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_REG: begin
        d.wb_reg_file = 1'b1;
        if (i[31:25] == F7_MULDIV) begin
          if (m_ext) d.m_type = 1'b1;
          else       d.invalid = 1'b1;
        end
      end
      default: d.invalid = 1'b1;
    endcase
    // an illegal instruction must never touch architectural state
    if (d.invalid) begin
      d.wb_reg_file = 1'b0; d.mem_write = 1'b0; d.wb_load = 1'b0; d.m_type = 1'b0;
    end
    return d;
  endfunction

  // {uses rs2, uses rs1} for load-use hazard detection
  function automatic logic [1:0] uses_rs(input logic [6:0] opcode);
    case (opcode)
      OP_REG, OP_BRANCH, OP_STORE: return 2'b11;
      OP_IMM, OP_LOAD, OP_JALR:    return 2'b01;
      default:                     return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bundle: fetch-side handshake, flush, writeback port and ID/EX payload.
interface decode_stage_pipe_if #(parameter int XLEN = 32);
  logic            in_valid, in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            id_flush;
  logic            wb_wr_en;
  logic [4:0]      wb_wr_addr;
  logic [XLEN-1:0] wb_wr_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_op1, out_op2, out_imm;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [6:0]      out_opcode, out_func7;
  logic [2:0]      out_func3;
  logic            out_alu_src, out_mem_write, out_wb_load, out_wb_reg_file, out_m_type, out_invalid;
  logic [2:0]      out_mem_load_type;
  logic [1:0]      out_mem_store_type;
  logic            stall_load_use;

  modport slave (
    input  in_valid, in_instr, in_pc, id_flush, wb_wr_en, wb_wr_addr, wb_wr_data, out_ready,
    output in_ready, out_valid, out_pc, out_op1, out_op2, out_imm, out_rs1, out_rs2, out_rd,
           out_opcode, out_func3, out_func7, out_alu_src, out_mem_write, out_wb_load,
           out_wb_reg_file, out_m_type, out_invalid, out_mem_load_type, out_mem_store_type,
           stall_load_use
  );

  modport master (
    output in_valid, in_instr, in_pc, id_flush, wb_wr_en, wb_wr_addr, wb_wr_data, out_ready,
    input  in_ready, out_valid, out_pc, out_op1, out_op2, out_imm, out_rs1, out_rs2, out_rd,
           out_opcode, out_func3, out_func7, out_alu_src, out_mem_write, out_wb_load,
           out_wb_reg_file, out_m_type, out_invalid, out_mem_load_type, out_mem_store_type,
           stall_load_use
  );
endinterface

// File: rtl/decode_stage_pipe_register_file.sv
// 32 x XLEN integer register file, two async read ports, one write port; x0 is hardwired zero.
module register_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [4:0]      rd_addr1,
  output logic [XLEN-1:0] rd_data1,
  input  logic [4:0]      rd_addr2,
  output logic [XLEN-1:0] rd_data2
);
  logic [XLEN-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (wr_en && wr_addr != '0) mem[wr_addr] <= wr_data;
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : mem[rd_addr2];
endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I(M) instruction decode stage: combinational decode, register read with
// write-through bypass, load-use bubble insertion and the ID/EX pipeline register.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter bit          M_EXT    = 1'b1,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input logic               clk,
  input logic               rst,
  decode_stage_pipe_if.slave bus
);
  localparam dec_t NOP_DEC = decode(NOP_INST, M_EXT);

  dec_t            dec, q;
  logic [1:0]      use_rs;
  logic [XLEN-1:0] rf_rd1, rf_rd2, op1, op2, pc_q, op1_q, op2_q;
  logic            vld_q, adv, haz, accept;

  assign dec    = decode(bus.in_instr, M_EXT);
  assign use_rs = uses_rs(bus.in_instr[6:0]);

  register_file #(.XLEN(XLEN)) u_rf (
    .clk      (clk),
    .wr_en    (bus.wb_wr_en),
    .wr_addr  (bus.wb_wr_addr),
    .wr_data  (bus.wb_wr_data),
    .rd_addr1 (dec.rs1),
    .rd_data1 (rf_rd1),
    .rd_addr2 (dec.rs2),
    .rd_data2 (rf_rd2)
  );

  // a writeback landing this cycle is newer than the stored copy
  assign op1 = (bus.wb_wr_en && bus.wb_wr_addr != '0 && bus.wb_wr_addr == dec.rs1) ? bus.wb_wr_data : rf_rd1;
  assign op2 = (bus.wb_wr_en && bus.wb_wr_addr != '0 && bus.wb_wr_addr == dec.rs2) ? bus.wb_wr_data : rf_rd2;

  assign adv = bus.out_ready | ~vld_q;
  assign haz = vld_q & q.wb_load & (q.rd != '0) & bus.in_valid &
               ((use_rs[0] & (q.rd == dec.rs1)) | (use_rs[1] & (q.rd == dec.rs2)));

  // flush consumes the incoming word even when it would have stalled
  assign bus.in_ready       = rst & adv & (bus.id_flush | ~haz);
  assign bus.stall_load_use = rst & adv & haz & ~bus.id_flush;
  assign accept             = bus.in_valid & bus.in_ready & ~bus.id_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      q     <= NOP_DEC;
      pc_q  <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else if (adv) begin
      vld_q <= accept;
      q     <= accept ? dec : NOP_DEC;
      pc_q  <= accept ? bus.in_pc : '0;
      op1_q <= accept ? op1 : '0;
      op2_q <= accept ? op2 : '0;
    end
  end

  assign bus.out_valid          = vld_q;
  assign bus.out_pc             = pc_q;
  assign bus.out_op1            = op1_q;
  assign bus.out_op2            = op2_q;
  assign bus.out_imm            = XLEN'($signed(q.imm));
  assign bus.out_rs1            = q.rs1;
  assign bus.out_rs2            = q.rs2;
  assign bus.out_rd             = q.rd;
  assign bus.out_opcode         = q.opcode;
  assign bus.out_func3          = q.func3;
  assign bus.out_func7          = q.func7;
  assign bus.out_alu_src        = q.alu_src;
  assign bus.out_mem_write      = q.mem_write;
  assign bus.out_wb_load        = q.wb_load;
  assign bus.out_wb_reg_file    = q.wb_reg_file;
  assign bus.out_m_type         = q.m_type;
  assign bus.out_invalid        = q.invalid;
  assign bus.out_mem_load_type  = q.mem_load_type;
  assign bus.out_mem_store_type = q.mem_store_type;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: expected ID/EX payloads are queued on accept
// and compared when the stage presents them.
module tb_decode_stage_pipe;
  import decode_stage_pipe_pkg::*;

  typedef struct packed {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        alu_src, mem_write, wb_load, wb_reg_file, m_type, invalid;
    logic [2:0]  lt;
    logic [1:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_pipe_if #(.XLEN(32)) bus ();
  decode_stage_pipe_if #(.XLEN(32)) bus0 ();

  decode_stage_pipe #(.XLEN(32), .M_EXT(1'b1), .NOP_INST(32'h0000_0013)) u_dut (
    .clk(clk), .rst(rst), .bus(bus));
  decode_stage_pipe #(.XLEN(32), .M_EXT(1'b0), .NOP_INST(32'h0000_0013)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));

  exp_t        sb[$];
  logic [31:0] rf_m [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic exp_t mk(input logic [31:0] instr, pc, imm, input logic [5:0] c,
                              input logic [2:0] lt, input logic [1:0] st);
    exp_t e;
    e.pc = pc; e.imm = imm;
    e.op1 = rf_m[instr[19:15]]; e.op2 = rf_m[instr[24:20]];
    e.rs1 = instr[19:15]; e.rs2 = instr[24:20]; e.rd = instr[11:7];
    e.opcode = instr[6:0]; e.func3 = instr[14:12]; e.func7 = instr[31:25];
    {e.alu_src, e.mem_write, e.wb_load, e.wb_reg_file, e.m_type, e.invalid} = c;
    e.lt = lt; e.st = st;
    return e;
  endfunction

  function automatic exp_t seen();
    exp_t g;
    g.pc = bus.out_pc; g.op1 = bus.out_op1; g.op2 = bus.out_op2; g.imm = bus.out_imm;
    g.rs1 = bus.out_rs1; g.rs2 = bus.out_rs2; g.rd = bus.out_rd;
    g.opcode = bus.out_opcode; g.func3 = bus.out_func3; g.func7 = bus.out_func7;
    g.alu_src = bus.out_alu_src; g.mem_write = bus.out_mem_write; g.wb_load = bus.out_wb_load;
    g.wb_reg_file = bus.out_wb_reg_file; g.m_type = bus.out_m_type; g.invalid = bus.out_invalid;
    g.lt = bus.out_mem_load_type; g.st = bus.out_mem_store_type;
    return g;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b/%b exp 0/0", bus.out_valid, bus0.out_valid);
    end
    n_tests++;
    if (bus.out_opcode !== 7'h13 || bus.out_pc !== 32'h0 || bus.out_op1 !== 32'h0 ||
        bus.out_op2 !== 32'h0 || bus.out_imm !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_payload got opc=%h pc=%h op1=%h op2=%h imm=%h exp 13/0/0/0/0",
               bus.out_opcode, bus.out_pc, bus.out_op1, bus.out_op2, bus.out_imm);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic [31:0] ti [8];
    logic [31:0] tm [8];
    logic [5:0]  tc [8];
    exp_t e;
    // rf preload; the x0 write must be dropped
    for (int r = 0; r < 32; r++) begin
      bus.wb_wr_en   = 1'b1;
      bus.wb_wr_addr = 5'(r);
      bus.wb_wr_data = (r == 0) ? 32'hBAD0_BAD0 : (r == 1) ? 32'd5 : (r == 2) ? 32'd9 :
                       32'h0101_0101 * 32'(r) + 32'h11;
      if (r != 0) rf_m[r] = bus.wb_wr_data;
      @(negedge clk);
    end
    rf_m[0] = 32'h0;
    bus.wb_wr_en = 1'b0;
    // addi, sw, beq, lui, jal, auipc, mul, undefined; tc = {alu_src,mem_wr,wb_load,wb_rf,m_type,invalid}
    ti = '{32'hFFD0_8113, 32'h0020_A423, 32'hFE20_8EE3, 32'h1234_52B7,
           32'h0010_00EF, 32'hFFFF_F197, 32'h0231_00B3, 32'h0000_007F};
    tm = '{32'hFFFF_FFFD, 32'h0000_0008, 32'hFFFF_FFFC, 32'h1234_5000,
           32'h0000_0800, 32'hFFFF_F000, 32'h0000_0000, 32'h0000_0000};
    tc = '{6'b100100, 6'b110000, 6'b000000, 6'b100100,
           6'b100100, 6'b100100, 6'b000110, 6'b000001};
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = ti[k];
      bus.in_pc    = 32'h100 + 32'(4 * k);
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL decode_ready[%0d] got %b exp 1", k, bus.in_ready); end
      sb.push_back(mk(ti[k], 32'h100 + 32'(4 * k), tm[k], tc[k], LT_NONE, (k == 1) ? ST_SW : ST_NONE));
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (bus.out_valid !== 1'b1 || seen() !== e) begin
        n_fail++; $display("FAIL decode[%0d] vld=%b got %h exp %h", k, bus.out_valid, seen(), e);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_load_use();
    exp_t e;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000_A183; bus.in_pc = 32'h200;   // lw x3,0(x1)
    #1;
    sb.push_back(mk(32'h0000_A183, 32'h200, 32'h0, 6'b101100, LT_LW, ST_NONE));
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (bus.out_valid !== 1'b1 || seen() !== e) begin
      n_fail++; $display("FAIL load_issue got %h exp %h", seen(), e);
    end
    bus.in_instr = 32'h0011_8233; bus.in_pc = 32'h204;                         // add x4,x3,x1
    #1;
    n_tests++;
    if (bus.stall_load_use !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_use_stall got stall=%b rdy=%b exp 1/0", bus.stall_load_use, bus.in_ready);
    end
    sb.push_back(mk(32'h0011_8233, 32'h204, 32'h0, 6'b000100, LT_NONE, ST_NONE));
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_opcode !== 7'h13 || bus.stall_load_use !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_use_bubble got vld=%b opc=%h stall=%b rdy=%b exp 0/13/0/1",
                         bus.out_valid, bus.out_opcode, bus.stall_load_use, bus.in_ready);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (bus.out_valid !== 1'b1 || seen() !== e) begin
      n_fail++; $display("FAIL load_use_reissue got %h exp %h", seen(), e);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_bypass();
    exp_t e;
    // sub x8,x7,x0 while x7 is being written
    bus.in_valid = 1'b1; bus.in_instr = 32'h4003_8433; bus.in_pc = 32'h300;
    bus.wb_wr_en = 1'b1; bus.wb_wr_addr = 5'd7; bus.wb_wr_data = 32'hDEAD_BEEF;
    e = mk(32'h4003_8433, 32'h300, 32'h0, 6'b000100, LT_NONE, ST_NONE);
    e.op1 = 32'hDEAD_BEEF;
    sb.push_back(e);
    @(negedge clk);
    rf_m[7] = 32'hDEAD_BEEF;
    e = sb.pop_front();
    n_tests++;
    if (bus.out_valid !== 1'b1 || seen() !== e) begin n_fail++; $display("FAIL bypass_rs1 got %h exp %h", seen(), e); end
    // add x9,x0,x7: stored value, and a concurrent x0 writeback must not leak into rs1
    bus.in_instr = 32'h0070_04B3; bus.in_pc = 32'h304;
    bus.wb_wr_addr = 5'd0; bus.wb_wr_data = 32'h5555_5555;
    sb.push_back(mk(32'h0070_04B3, 32'h304, 32'h0, 6'b000100, LT_NONE, ST_NONE));
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (bus.out_valid !== 1'b1 || seen() !== e) begin n_fail++; $display("FAIL bypass_x0_readback got %h exp %h", seen(), e); end
    // add x10,x0,x5 with x5 written the same cycle
    bus.in_instr = 32'h0050_0533; bus.in_pc = 32'h308;
    bus.wb_wr_addr = 5'd5; bus.wb_wr_data = 32'h1234_5678;
    e = mk(32'h0050_0533, 32'h308, 32'h0, 6'b000100, LT_NONE, ST_NONE);
    e.op2 = 32'h1234_5678;
    sb.push_back(e);
    @(negedge clk);
    rf_m[5] = 32'h1234_5678;
    e = sb.pop_front();
    n_tests++;
    if (bus.out_valid !== 1'b1 || seen() !== e) begin n_fail++; $display("FAIL bypass_rs2 got %h exp %h", seen(), e); end
    bus.in_valid = 1'b0; bus.wb_wr_en = 1'b0;
  endtask

  task automatic test_backpressure_flush();
    exp_t e;
    bus.in_valid = 1'b1; bus.in_instr = 32'hFFD0_8113; bus.in_pc = 32'h400;
    sb.push_back(mk(32'hFFD0_8113, 32'h400, 32'hFFFF_FFFD, 6'b100100, LT_NONE, ST_NONE));
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_instr = 32'h1234_52B7; bus.in_pc = 32'h404;
    e = sb.pop_front();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || seen() !== e) begin
        n_fail++; $display("FAIL hold[%0d] rdy=%b vld=%b got %h exp 0/1 %h", c, bus.in_ready, bus.out_valid, seen(), e);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1; bus.id_flush = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_opcode !== 7'h13) begin
      n_fail++; $display("FAIL flush_bubble got vld=%b opc=%h exp 0/13", bus.out_valid, bus.out_opcode);
    end
    bus.id_flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_m_ext_off();
    bus0.in_valid = 1'b1; bus0.in_instr = 32'h0231_00B3; bus0.in_pc = 32'h500;   // mul x1,x2,x3
    #1;
    n_tests++;
    if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL mext0_ready got %b exp 1", bus0.in_ready); end
    @(negedge clk);
    n_tests++;
    if (bus0.out_valid !== 1'b1 || bus0.out_invalid !== 1'b1 || bus0.out_m_type !== 1'b0 ||
        bus0.out_wb_reg_file !== 1'b0) begin
      n_fail++; $display("FAIL mext0_mul got vld=%b inv=%b m=%b wb=%b exp 1/1/0/0",
                         bus0.out_valid, bus0.out_invalid, bus0.out_m_type, bus0.out_wb_reg_file);
    end
    bus0.in_valid = 1'b0;
  endtask

  task automatic test_reset_midstall();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000_A183; bus.in_pc = 32'h600;
    @(negedge clk);
    bus.in_instr = 32'h0011_8233; bus.in_pc = 32'h604;
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.stall_load_use !== 1'b0) begin
      n_fail++; $display("FAIL rst_stall_ready got rdy=%b stall=%b exp 0/0", bus.in_ready, bus.stall_load_use);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_replay got vld=%b exp 0", bus.out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal;
  end

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;  bus.in_instr = 32'h13;  bus.in_pc = '0;  bus.id_flush = 1'b0;
    bus.wb_wr_en = 1'b0;  bus.wb_wr_addr = '0;    bus.wb_wr_data = '0; bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_instr = 32'h13; bus0.in_pc = '0; bus0.id_flush = 1'b0;
    bus0.wb_wr_en = 1'b0; bus0.wb_wr_addr = '0;   bus0.wb_wr_data = '0; bus0.out_ready = 1'b1;
    test_reset();
    test_decode();
    test_load_use();
    test_bypass();
    test_backpressure_flush();
    test_m_ext_off();
    test_reset_midstall();
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
